bcd_number_reader: RTL and testbench

//  Reads back the 10-digit BCD vector built by the digit-entry memory and converts it to binary.
//  - Digit 0 (bits [3:0]) is the first digit keyed in, so it is the most significant digit.
//  - One digit is consumed per clock with acc = acc*10 + digit.
//  - Sits between the number-entry store and the ALU operand registers.
//  - Start/busy/done handshake; result is held until the next conversion.

---
 rtl/bcd_number_reader.sv | 163 ++++++++++++++++
 tb/tb_bcd_number_reader.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/bcd_number_reader.sv
// bcd_number_reader: converts a latched vector of up to NUM_DIGITS BCD digits
// into binary, most significant digit first (digit 0 = first digit keyed in).
// One digit per clock, acc = acc*10 + digit, with sticky overflow and
// bad-digit flags published together with a one-cycle done pulse.
// Optional build macro SATURATE_EN: on overflow the accumulator saturates to
// all ones instead of wrapping modulo 2^OUT_W.
module bcd_number_reader #(
  parameter int NUM_DIGITS = 10,
  parameter int OUT_W      = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [4*NUM_DIGITS-1:0] num_in,
  input  logic [3:0]              count_in,
  output logic                    busy,
  output logic                    done,
  output logic [OUT_W-1:0]        value,
  output logic                    overflow,
  output logic                    bad_digit
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PW    = OUT_W + 4;  // acc*10 + 9 always fits in OUT_W+4 bits

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONV,
    S_DONE
  } state_t;

  state_t                    state_q, state_d;
  logic [4*NUM_DIGITS-1:0]   num_q, num_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [IDX_W-1:0]          last_q, last_d;     // index of the final digit
  logic [OUT_W-1:0]          acc_q, acc_d;
  logic                      ovf_q, ovf_d;       // working sticky overflow
  logic                      bad_q, bad_d;       // working sticky bad digit
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic [OUT_W-1:0]          value_q, value_d;
  logic                      overflow_q, overflow_d;
  logic                      bad_digit_q, bad_digit_d;

  logic [3:0]                digits [NUM_DIGITS];
  logic [3:0]                n_clamp;
  logic [3:0]                digit_eff;
  logic                      digit_bad;
  logic [PW-1:0]             step;
  logic                      step_ovf;

  // Split the latched vector into individually addressable digits.
  always_comb begin
    for (int i = 0; i < NUM_DIGITS; i++) begin
      digits[i] = num_q[4*i +: 4];
    end
  end

  // One accumulation step on the current digit; invalid digits count as zero.
  always_comb begin
    digit_bad = (digits[idx_q] > 4'd9);
    digit_eff = digit_bad ? 4'd0 : digits[idx_q];
    step      = PW'(acc_q) * PW'(10) + PW'(digit_eff);
    step_ovf  = |step[PW-1:OUT_W];
    n_clamp   = (count_in > 4'(NUM_DIGITS)) ? 4'(NUM_DIGITS) : count_in;
  end

  // Next-state and next-output computation for the IDLE/CONV/DONE sequencer.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d     = state_q;
    num_d       = num_q;
    idx_d       = idx_q;
    last_d      = last_q;
    acc_d       = acc_q;
    ovf_d       = ovf_q;
    bad_d       = bad_q;
    value_d     = value_q;
    overflow_d  = overflow_q;
    bad_digit_d = bad_digit_q;
    done_d      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          num_d   = num_in;
          idx_d   = '0;
          acc_d   = '0;
          ovf_d   = 1'b0;
          bad_d   = 1'b0;
          last_d  = IDX_W'(n_clamp - 4'd1);
          state_d = (n_clamp == 4'd0) ? S_DONE : S_CONV;
        end
      end
      S_CONV: begin
        if (digit_bad) bad_d = 1'b1;
        if (step_ovf)  ovf_d = 1'b1;
`ifdef SATURATE_EN
        acc_d = (ovf_q || step_ovf) ? {OUT_W{1'b1}} : step[OUT_W-1:0];
`else
        acc_d = step[OUT_W-1:0];
`endif
        // Stop on the last digit without advancing, so idx stays in range.
        if (idx_q == last_q) begin
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      S_DONE: begin
        done_d      = 1'b1;
        value_d     = acc_q;
        overflow_d  = ovf_q;
        bad_digit_d = bad_q;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and registered outputs; synchronous reset aborts any conversion.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples values from before this edge.
    if (reset) begin
      state_q     <= S_IDLE;
      num_q       <= '0;
      idx_q       <= '0;
      last_q      <= '0;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      bad_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      value_q     <= '0;
      overflow_q  <= 1'b0;
      bad_digit_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      num_q       <= num_d;
      idx_q       <= idx_d;
      last_q      <= last_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      bad_q       <= bad_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      value_q     <= value_d;
      overflow_q  <= overflow_d;
      bad_digit_q <= bad_digit_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign value     = value_q;
  assign overflow  = overflow_q;
  assign bad_digit = bad_digit_q;

endmodule

// File: tb/tb_bcd_number_reader.sv
// Testbench for bcd_number_reader: directed cases plus randomized conversions
// checked against a digit-by-digit arithmetic reference model.
module tb_bcd_number_reader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [39:0] num_in;
  logic [3:0]  count_in;
  logic        busy;
  logic        done;
  logic [31:0] value;
  logic        overflow;
  logic        bad_digit;

  int checks   = 0;
  int failures = 0;

  bcd_number_reader #(.NUM_DIGITS(10), .OUT_W(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .num_in    (num_in),
    .count_in  (count_in),
    .busy      (busy),
    .done      (done),
    .value     (value),
    .overflow  (overflow),
    .bad_digit (bad_digit)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: decimal value of the first min(cnt,10) digits, MSD first.
  function automatic void model(input logic [39:0] num, input int cnt,
                                output logic [31:0] v, output bit ov, output bit bd);
    longint acc;
    int     n;
    int     d;
    acc = 0;
    ov  = 1'b0;
    bd  = 1'b0;
    n   = (cnt > 10) ? 10 : cnt;
    for (int i = 0; i < n; i++) begin
      d = int'(num[4*i +: 4]);
      if (d > 9) begin
        bd = 1'b1;
        d  = 0;
      end
      acc = acc * 10 + d;
      if (acc >= 64'sd4294967296) begin
        ov = 1'b1;
`ifdef SATURATE_EN
        acc = 64'sd4294967295;
`else
        acc = acc % 64'sd4294967296;
`endif
      end
    end
    v = acc[31:0];
  endfunction

  function automatic logic [39:0] rand_bits();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[39:0];
  endfunction

  // One conversion: checks latency, busy length, result, flags and hold.
  // poke pulses start (with different data) one cycle after acceptance.
  task automatic run(input logic [39:0] num, input logic [3:0] cnt,
                     input logic [31:0] ev, input bit eov, input bit ebd,
                     input bit poke, input string tag);
    int n;
    int cyc;
    int busy_cyc;
    bit got;
    n        = (cnt > 4'd10) ? 10 : int'(cnt);
    cyc      = 0;
    busy_cyc = 0;
    got      = 1'b0;
    @(negedge clk);
    num_in   = num;
    count_in = cnt;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    num_in   = rand_bits();
    count_in = 4'($urandom_range(0, 15));
    chk({tag, "_busy_start"}, 64'(busy), 64'd1);
    if (busy) busy_cyc++;
    for (int k = 0; k < 20; k++) begin
      if (poke && k == 0) begin
        start  = 1'b1;
        num_in = rand_bits();
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      cyc++;
      if (busy) busy_cyc++;
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    chk({tag, "_done_seen"}, 64'(got), 64'd1);
    chk({tag, "_latency"}, 64'(cyc), 64'(n + 1));
    chk({tag, "_busy_len"}, 64'(busy_cyc), 64'(n + 1));
    chk({tag, "_value"}, 64'(value), 64'(ev));
    chk({tag, "_overflow"}, 64'(overflow), 64'(eov));
    chk({tag, "_bad_digit"}, 64'(bad_digit), 64'(ebd));
    @(posedge clk);
    #1;
    chk({tag, "_done_pulse"}, 64'(done), 64'd0);
    chk({tag, "_value_hold"}, 64'(value), 64'(ev));
  endtask

  initial begin : main
    logic [31:0] ev;
    bit          eov;
    bit          ebd;
    logic [39:0] num;
    int          cnt;
    int          d;
    bit          saw_done;

    reset    = 1'b1;
    start    = 1'b0;
    num_in   = '0;
    count_in = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_value", 64'(value), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    chk("rst_bad_digit", 64'(bad_digit), 64'd0);
    reset = 1'b0;

    // Directed cases.
    run(40'h0000000321, 4'd3, 32'd123, 1'b0, 1'b0, 1'b0, "t1_123");
    run(40'h0000000000, 4'd0, 32'd0, 1'b0, 1'b0, 1'b0, "t2_empty");
`ifdef SATURATE_EN
    run(40'h9999999999, 4'd10, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, "t3_ovf");
`else
    run(40'h9999999999, 4'd10, 32'h540BE3FF, 1'b1, 1'b0, 1'b0, "t3_ovf");
`endif
    run(40'h5927694924, 4'd12, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, "t4_clamp_max");
    run(40'h00000000A1, 4'd2, 32'd10, 1'b0, 1'b1, 1'b0, "t5_bad");
    run(40'h0000004321, 4'd4, 32'd1234, 1'b0, 1'b0, 1'b1, "ign_conv");
    run(40'h0000000000, 4'd0, 32'd0, 1'b0, 1'b0, 1'b1, "ign_done");
    run(40'h0000000007, 4'd1, 32'd7, 1'b0, 1'b0, 1'b0, "one_digit");

    // Reset in the middle of a 10-digit conversion: no done, outputs cleared.
    @(negedge clk);
    num_in   = 40'h1111111111;
    count_in = 4'd10;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b1;        // ignored start during CONV
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_value", 64'(value), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_overflow", 64'(overflow), 64'd0);
    saw_done = 1'b0;
    for (int k = 0; k < 14; k++) begin
      @(posedge clk);
      #1;
      if (done || busy) saw_done = 1'b1;
    end
    chk("abort_no_done", 64'(saw_done), 64'd0);
    run(40'h0000000321, 4'd3, 32'd123, 1'b0, 1'b0, 1'b0, "after_abort");

    // Randomized conversions against the reference model.
    for (int t = 0; t < 30; t++) begin
      num = '0;
      for (int i = 0; i < 10; i++) begin
        d = ($urandom_range(0, 7) == 0) ? int'($urandom_range(10, 15))
                                        : int'($urandom_range(0, 9));
        num[4*i +: 4] = 4'(d);
      end
      cnt = int'($urandom_range(0, 15));
      model(num, cnt, ev, eov, ebd);
      run(num, 4'(cnt), ev, eov, ebd, bit'($urandom_range(0, 1)), $sformatf("rnd%0d", t));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
